fir_output_requantizer: RTL

- Downstream of the polyphase halfband decimating FIR.
- Accepts the FIR's wide signed accumulator output in Q(FRAC_BITS) at one sample per valid_in strobe.
- Applies round-half-up and arithmetic right shift, saturates to OUT_WIDTH bits, and buffers results in a small FIFO.
- Presents the FIFO to the next stage with a valid/ready handshake. The FIR has no backpressure, so overflow drops samples and counts them.

---
 rtl/fir_output_requantizer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fir_output_requantizer.sv
// Requantizes the halfband FIR accumulator: round-half-up, saturate to OUT_WIDTH,
// buffer in a show-ahead FIFO with valid/ready output and saturating event counters.
module fir_output_requantizer #(
  parameter int ACC_WIDTH  = 24,
  parameter int FRAC_BITS  = 16,
  parameter int OUT_WIDTH  = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [ACC_WIDTH-1:0]          data_in,
  output logic                          valid_out,
  output logic [OUT_WIDTH-1:0]          data_out,
  input  logic                          ready_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          sat_count,
  output logic [CNT_WIDTH-1:0]          drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = ACC_WIDTH + 1 - FRAC_BITS;
  localparam int CW = ((RW > OUT_WIDTH) ? RW : OUT_WIDTH) + 1;

  localparam logic [ACC_WIDTH:0] HALF    = (ACC_WIDTH + 1)'(1) << (FRAC_BITS - 1);
  localparam logic [CW-1:0]      SAT_MAX = {{(CW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [CW-1:0]      SAT_MIN = {{(CW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic [ACC_WIDTH:0]   round_sum;
  logic                 unused_round_lsbs;
  logic [RW-1:0]        s1_data_d, s1_data_q;
  logic                 s1_valid_q;
  logic [CW-1:0]        r_ext;
  logic                 clip_d;
  logic [OUT_WIDTH-1:0] s2_data_d, s2_data_q;
  logic                 s2_valid_q;

  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_d, level_q;
  logic                 full, pop, write, drop;
  logic [CNT_WIDTH-1:0] sat_q, drop_q;

  // One extra MSB keeps the rounding add from wrapping at the positive limit.
  always_comb begin
    round_sum = {data_in[ACC_WIDTH-1], data_in} + HALF;
    s1_data_d = round_sum[ACC_WIDTH:FRAC_BITS];
  end
  assign unused_round_lsbs = ^round_sum[FRAC_BITS-1:0];

  always_comb begin
    r_ext     = {{(CW - RW){s1_data_q[RW-1]}}, s1_data_q};
    clip_d    = 1'b0;
    s2_data_d = r_ext[OUT_WIDTH-1:0];
    if ($signed(r_ext) > $signed(SAT_MAX)) begin
      s2_data_d = SAT_MAX[OUT_WIDTH-1:0];
      clip_d    = 1'b1;
    end else if ($signed(r_ext) < $signed(SAT_MIN)) begin
      s2_data_d = SAT_MIN[OUT_WIDTH-1:0];
      clip_d    = 1'b1;
    end
  end

  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign valid_out = (level_q != '0);
  assign pop       = valid_out && ready_in;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign write     = s2_valid_q && (!full || pop);
  assign drop      = s2_valid_q && full && !pop;

  always_comb begin
    level_d = level_q;
    if (write && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!write && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sat_q      <= '0;
      drop_q     <= '0;
    end else begin
      s1_valid_q <= valid_in;
      s2_valid_q <= s1_valid_q;
      level_q    <= level_d;
      if (s1_valid_q && clip_d && (sat_q != '1)) begin
        sat_q <= sat_q + CNT_WIDTH'(1);
      end
      if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + CNT_WIDTH'(1);
      end
      if (write) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in) begin
      s1_data_q <= s1_data_d;
    end
    if (s1_valid_q) begin
      s2_data_q <= s2_data_d;
    end
    if (write && !reset) begin
      mem_q[wr_ptr_q] <= s2_data_q;
    end
  end

  assign data_out   = valid_out ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign sat_count  = sat_q;
  assign drop_count = drop_q;

endmodule
